htif_word_adapter: RTL and testbench

//  Parametrised bridge between word-wide host FIFOs on the ARM-facing AXI side and the narrow HTIF port of Top.

---
 rtl/htif_word_adapter.sv | 165 ++++++++++++++++
 tb/tb_htif_word_adapter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/htif_word_adapter.sv
// Word <-> HTIF beat bridge: serialises host words into narrow beats toward Top and
// packs beats from Top into words held in an occupancy-reporting output FIFO.
module htif_word_adapter #(
   parameter int WORD_BITS     = 32,
   parameter int HTIF_BITS     = 16,
   parameter int OUT_DEPTH     = 32,
   parameter int FLUSH_TIMEOUT = 0
) (
   input  logic                                           clk,
   input  logic                                           reset,
   input  logic                                           in_valid,
   output logic                                           in_ready,
   input  logic [WORD_BITS-1:0]                           in_bits,
   output logic                                           host_in_valid,
   input  logic                                           host_in_ready,
   output logic [HTIF_BITS-1:0]                           host_in_bits,
   input  logic                                           host_out_valid,
   output logic                                           host_out_ready,
   input  logic [HTIF_BITS-1:0]                           host_out_bits,
   input  logic                                           flush,
   output logic                                           out_valid,
   input  logic                                           out_ready,
   output logic [WORD_BITS-1:0]                           out_bits,
   output logic [$clog2((WORD_BITS/HTIF_BITS)+1)-1:0]     out_lanes,
   output logic [$clog2(OUT_DEPTH+1)-1:0]                 out_count
);

   localparam int R      = WORD_BITS / HTIF_BITS;
   localparam int IDX_W  = $clog2(R);
   localparam int LANE_W = $clog2(R + 1);
   localparam int CNT_W  = $clog2(OUT_DEPTH + 1);
   localparam int PTR_W  = $clog2(OUT_DEPTH);
   localparam int TMR_W  = (FLUSH_TIMEOUT > 0) ? $clog2(FLUSH_TIMEOUT + 1) : 1;

   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(R - 1);
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(OUT_DEPTH);
   localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(FLUSH_TIMEOUT);
   localparam logic [TMR_W-1:0] TMR_MAX   = '1;

   logic [IDX_W-1:0]     dn_idx;
   logic [HTIF_BITS-1:0] dn_beat;
   logic                 dn_fire;

   logic [IDX_W-1:0]     pk_idx;
   logic [WORD_BITS-1:0] pk_data;
   logic [WORD_BITS-1:0] full_word;
   logic [TMR_W-1:0]     timer;
   logic                 flush_pend;
   logic                 up_fire;
   logic                 word_done;
   logic                 timeout_hit;
   logic                 pend_eff;
   logic                 do_flush;

   logic [WORD_BITS-1:0] mem       [OUT_DEPTH];
   logic [LANE_W-1:0]    lanes_mem [OUT_DEPTH];
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;
   logic [CNT_W-1:0]     count;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic                 push;
   logic                 pop;
   logic [WORD_BITS-1:0] push_data;
   logic [LANE_W-1:0]    push_lanes;

   // Down path: the host word is held upstream until its last lane goes out.
   always_comb begin
      dn_beat = '0;
      for (int k = 0; k < R; k++) begin
         if (dn_idx == IDX_W'(k)) dn_beat = in_bits[k*HTIF_BITS +: HTIF_BITS];
      end
   end

   assign host_in_valid = !reset && in_valid;
   assign host_in_bits  = dn_beat;
   assign in_ready      = !reset && host_in_ready && (dn_idx == LAST_IDX);
   assign dn_fire       = host_in_valid && host_in_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         dn_idx <= '0;
      end else if (dn_fire) begin
         dn_idx <= (dn_idx == LAST_IDX) ? '0 : dn_idx + 1'b1;
      end
   end

   assign fifo_full      = (count == DEPTH_CNT);
   assign fifo_empty     = (count == '0);
   assign host_out_ready = !reset && !((pk_idx == LAST_IDX) && fifo_full);
   assign up_fire        = host_out_valid && host_out_ready;
   assign word_done      = up_fire && (pk_idx == LAST_IDX);

   // A pending flush only fires in a cycle with no incoming beat, so pushes never collide.
   assign timeout_hit = (FLUSH_TIMEOUT != 0) && (timer == TMR_LIMIT);
   assign pend_eff    = flush_pend || flush || timeout_hit;
   assign do_flush    = pend_eff && (pk_idx != '0) && !fifo_full && !up_fire;

   always_comb begin
      full_word = pk_data;
      full_word[(R-1)*HTIF_BITS +: HTIF_BITS] = host_out_bits;
   end

   assign push       = word_done || do_flush;
   assign push_data  = word_done ? full_word : pk_data;
   assign push_lanes = word_done ? LANE_W'(R) : LANE_W'(pk_idx);

   always_ff @(posedge clk) begin
      if (reset) begin
         pk_idx     <= '0;
         pk_data    <= '0;
         flush_pend <= 1'b0;
         timer      <= '0;
      end else begin
         if (push) begin
            pk_idx  <= '0;
            pk_data <= '0;
         end else if (up_fire) begin
            pk_idx <= pk_idx + 1'b1;
            for (int k = 0; k < R; k++) begin
               if (pk_idx == IDX_W'(k)) pk_data[k*HTIF_BITS +: HTIF_BITS] <= host_out_bits;
            end
         end
         // With nothing packed and no beat arriving there is nothing to flush, so drop the request.
         flush_pend <= pend_eff && !do_flush && !((pk_idx == '0) && !up_fire);
         if (up_fire || do_flush) begin
            timer <= '0;
         end else if ((pk_idx != '0) && !flush_pend && (timer != TMR_MAX)) begin
            timer <= timer + 1'b1;
         end
      end
   end

   assign pop = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset; the pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (push && !reset) begin
         mem[wr_ptr]       <= push_data;
         lanes_mem[wr_ptr] <= push_lanes;
      end
   end

   assign out_valid = !reset && !fifo_empty;
   assign out_bits  = out_valid ? mem[rd_ptr] : '0;
   assign out_lanes = out_valid ? lanes_mem[rd_ptr] : '0;
   assign out_count = reset ? '0 : count;

endmodule

// File: tb/tb_htif_word_adapter.sv
// Randomised and directed bench for htif_word_adapter, checked against a queue-based
// transaction model of the packer, serialiser and output FIFO.
module tb_htif_word_adapter;

   localparam int LANES = 2;
   localparam int DEPTH = 32;
   localparam int TMO   = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_bits;
   logic        host_in_valid;
   logic        host_in_ready;
   logic [15:0] host_in_bits;
   logic        host_out_valid;
   logic        host_out_ready;
   logic [15:0] host_out_bits;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_bits;
   logic [1:0]  out_lanes;
   logic [5:0]  out_count;

   int num_checks = 0;
   int num_errors = 0;

   typedef struct {
      logic [31:0] data;
      int          lanes;
   } word_t;

   word_t       q[$];
   int          m_dn;
   int          m_pk;
   logic [31:0] m_pkd;
   int          m_idle;
   bit          m_pend;

   htif_word_adapter #(
      .WORD_BITS(32),
      .HTIF_BITS(16),
      .OUT_DEPTH(DEPTH),
      .FLUSH_TIMEOUT(TMO)
   ) dut (
      .clk(clk),
      .reset(reset),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_bits(in_bits),
      .host_in_valid(host_in_valid),
      .host_in_ready(host_in_ready),
      .host_in_bits(host_in_bits),
      .host_out_valid(host_out_valid),
      .host_out_ready(host_out_ready),
      .host_out_bits(host_out_bits),
      .flush(flush),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_bits(out_bits),
      .out_lanes(out_lanes),
      .out_count(out_count)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      num_checks++;
      if (observed !== expected) begin
         num_errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic iv, input logic [31:0] ib, input logic hir,
                                input logic hov, input logic [15:0] hob,
                                input logic fl, input logic ordy);
      in_valid       = iv;
      in_bits        = ib;
      host_in_ready  = hir;
      host_out_valid = hov;
      host_out_bits  = hob;
      flush          = fl;
      out_ready      = ordy;
   endtask

   // Compare every output against the model for the current state and inputs.
   task automatic checkCycle();
      if (reset) begin
         checkOutput("rst_in_ready", in_ready, 0);
         checkOutput("rst_host_in_valid", host_in_valid, 0);
         checkOutput("rst_host_out_ready", host_out_ready, 0);
         checkOutput("rst_out_valid", out_valid, 0);
         checkOutput("rst_out_count", out_count, 0);
         checkOutput("rst_out_bits", out_bits, 0);
         checkOutput("rst_out_lanes", out_lanes, 0);
      end else begin
         checkOutput("in_ready", in_ready, host_in_ready && (m_dn == LANES - 1));
         checkOutput("host_in_valid", host_in_valid, in_valid);
         checkOutput("host_in_bits", host_in_bits, in_bits[m_dn*16 +: 16]);
         checkOutput("host_out_ready", host_out_ready, !((m_pk == LANES - 1) && (q.size() == DEPTH)));
         checkOutput("out_count", out_count, q.size());
         checkOutput("out_valid", out_valid, q.size() != 0);
         if (q.size() != 0) begin
            checkOutput("out_bits", out_bits, q[0].data);
            checkOutput("out_lanes", out_lanes, q[0].lanes);
         end
      end
   endtask

   task automatic modelUpdate();
      int    pk0;
      bit    pend0, full, fire, pend_eff, flushed, popped, pushed;
      word_t w;
      if (reset) begin
         m_dn = 0; m_pk = 0; m_pkd = '0; m_idle = 0; m_pend = 0;
         q.delete();
         return;
      end
      if (in_valid && host_in_ready) m_dn = (m_dn + 1) % LANES;
      pk0      = m_pk;
      pend0    = m_pend;
      full     = (q.size() == DEPTH);
      fire     = host_out_valid && !((m_pk == LANES - 1) && full);
      pend_eff = m_pend || flush || (m_idle == TMO);
      popped   = (q.size() != 0) && out_ready;
      pushed   = 0;
      flushed  = 0;
      w.data   = '0;
      w.lanes  = 0;
      if (fire) begin
         m_pkd[m_pk*16 +: 16] = host_out_bits;
         m_pk++;
         if (m_pk == LANES) begin
            w.data = m_pkd; w.lanes = LANES; pushed = 1;
            m_pk = 0; m_pkd = '0;
         end
      end else if (pend_eff && (m_pk != 0) && !full) begin
         w.data = m_pkd; w.lanes = m_pk; pushed = 1; flushed = 1;
         m_pk = 0; m_pkd = '0;
      end
      if (flushed || (pk0 == 0 && !fire)) m_pend = 0;
      else m_pend = pend_eff;
      if (fire || flushed) m_idle = 0;
      else if (pk0 != 0 && !pend0) m_idle++;
      if (popped) void'(q.pop_front());
      if (pushed) q.push_back(w);
   endtask

   task automatic tick();
      #1;
      checkCycle();
      @(posedge clk);
      modelUpdate();
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1;
      applyStimulus(1, 32'h0F0F_0F0F, 1, 1, 16'h5555, 1, 1);
      m_dn = 0; m_pk = 0; m_pkd = '0; m_idle = 0; m_pend = 0;
      repeat (3) tick();
      reset = 1'b0;

      // Serialise one word: low lane first, pop only on the last lane.
      applyStimulus(1, 32'hBEEF_CAFE, 1, 0, 0, 0, 0);
      #1;
      checkOutput("ser_lane0", host_in_bits, 16'hCAFE);
      checkOutput("ser_ready0", in_ready, 0);
      tick();
      #1;
      checkOutput("ser_lane1", host_in_bits, 16'hBEEF);
      checkOutput("ser_ready1", in_ready, 1);
      tick();

      // Pack two beats into one word.
      applyStimulus(0, 0, 0, 1, 16'h1234, 0, 0);
      tick();
      applyStimulus(0, 0, 0, 1, 16'h5678, 0, 0);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      #1;
      checkOutput("pack_valid", out_valid, 1);
      checkOutput("pack_bits", out_bits, 32'h5678_1234);
      checkOutput("pack_lanes", out_lanes, 2);
      checkOutput("pack_count", out_count, 1);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 1);
      tick();

      // Fill the FIFO, stall on the last lane, release with one pop.
      for (int i = 0; i < 2 * DEPTH; i++) begin
         applyStimulus(0, 0, 0, 1, 16'($urandom), 0, 0);
         tick();
      end
      applyStimulus(0, 0, 0, 1, 16'h1111, 0, 0);
      #1;
      checkOutput("fill_count", out_count, DEPTH);
      checkOutput("fill_rdy_lane0", host_out_ready, 1);
      tick();
      #1;
      checkOutput("fill_rdy_stall", host_out_ready, 0);
      tick();
      tick();
      applyStimulus(0, 0, 0, 1, 16'h2222, 0, 1);
      #1;
      checkOutput("fill_rdy_popcycle", host_out_ready, 0);
      tick();
      applyStimulus(0, 0, 0, 1, 16'h2222, 0, 0);
      #1;
      checkOutput("fill_rdy_after_pop", host_out_ready, 1);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 1);
      repeat (DEPTH + 4) tick();

      // Explicit flush of a one-lane word, then a flush with nothing packed.
      applyStimulus(0, 0, 0, 1, 16'hABCD, 0, 0);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 1, 0);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      #1;
      checkOutput("flush_bits", out_bits, 32'h0000_ABCD);
      checkOutput("flush_lanes", out_lanes, 1);
      checkOutput("flush_count", out_count, 1);
      applyStimulus(0, 0, 0, 0, 0, 1, 0);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      #1;
      checkOutput("flush_empty_count", out_count, 1);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 1);
      tick();

      // Idle timeout: partial word leaves on the ninth idle cycle.
      applyStimulus(0, 0, 0, 1, 16'h1357, 0, 0);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      repeat (TMO) tick();
      #1;
      checkOutput("tmo_before", out_count, 0);
      tick();
      #1;
      checkOutput("tmo_push", out_count, 1);
      checkOutput("tmo_lanes", out_lanes, 1);
      checkOutput("tmo_bits", out_bits, 32'h0000_1357);
      applyStimulus(0, 0, 0, 0, 0, 0, 1);
      tick();

      // Second beat on idle cycle 7 completes the word before the timeout.
      applyStimulus(0, 0, 0, 1, 16'h2468, 0, 0);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      repeat (6) tick();
      applyStimulus(0, 0, 0, 1, 16'h9ABC, 0, 0);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      repeat (12) tick();
      #1;
      checkOutput("tmo_full_count", out_count, 1);
      checkOutput("tmo_full_lanes", out_lanes, 2);
      checkOutput("tmo_full_bits", out_bits, 32'h9ABC_2468);
      applyStimulus(0, 0, 0, 0, 0, 0, 1);
      tick();

      // Reset with a half-sent host word and three packed words plus a partial one.
      applyStimulus(1, 32'h1122_3344, 1, 0, 0, 0, 0);
      tick();
      for (int i = 0; i < 7; i++) begin
         applyStimulus(0, 32'h1122_3344, 0, 1, 16'($urandom), 0, 0);
         tick();
      end
      reset = 1'b1;
      applyStimulus(1, 32'h1122_3344, 0, 0, 0, 0, 0);
      tick();
      reset = 1'b0;
      applyStimulus(1, 32'h1122_3344, 1, 0, 0, 0, 0);
      #1;
      checkOutput("rst_mid_lane0", host_in_bits, 16'h3344);
      checkOutput("rst_mid_valid", out_valid, 0);
      checkOutput("rst_mid_count", out_count, 0);
      tick();

      // Random traffic with phases of slow draining to reach a full FIFO.
      for (int i = 0; i < 4000; i++) begin
         int ordy_pct;
         ordy_pct = ((i / 500) % 2 == 0) ? 70 : 15;
         reset = ($urandom_range(0, 399) == 0);
         applyStimulus($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) != 0,
                       $urandom_range(0, 2) != 0, 16'($urandom),
                       $urandom_range(0, 15) == 0, $urandom_range(0, 99) < ordy_pct);
         if ($urandom_range(0, 9) == 0) host_out_valid = 1'b0;
         tick();
      end
      reset = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
      $finish;
   end

endmodule
